// File: rtl/booth_dot_accumulator.sv
// ============================================================================
// booth_dot_accumulator
//
// Sequential dot-product stage wrapped around an external combinational 4x4
// radix-4 Booth multiplier. Operand pairs are accepted over a valid/ready
// handshake and registered onto the multiplier inputs. The 8-bit product
// that comes back is sign-extended and accumulated over LEN pairs. The sum is
// then presented over an output valid/ready handshake.
//
// Parameters
//   LEN    operand pairs per dot product (1..255)
//   ACC_W  signed accumulator / result width in bits (8..32)
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   operand pair valid
//   in_ready      out  block can accept a pair (high only in ACC)
//   in_mr         in   [3:0] multiplier operand, two's complement
//   in_md         in   [3:0] multiplicand operand, two's complement
//   mult_mr       out  [3:0] registered operand to multiplier MR input
//   mult_md       out  [3:0] registered operand to multiplier MD input
//   mult_product  in   [7:0] product, combinational from mult_mr/mult_md
//   out_valid     out  result valid (high only in DONE)
//   out_ready     in   consumer accepts the result
//   out_sum       out  [ACC_W-1:0] signed accumulated sum
//   out_ovf       out  sticky signed-overflow flag for this result
// ============================================================================
module booth_dot_accumulator #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_mr,
    input  logic [3:0]       in_md,
    output logic [3:0]       mult_mr,
    output logic [3:0]       mult_md,
    input  logic [7:0]       mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = (LEN < 2) ? 1 : $clog2(LEN + 1);

    // Parameter legality is checked at elaboration time.
    if (LEN < 1 || LEN > 255) begin : g_bad_len
        $error("booth_dot_accumulator: LEN must be in 1..255");
    end
    if (ACC_W < 8 || ACC_W > 32) begin : g_bad_accw
        $error("booth_dot_accumulator: ACC_W must be in 8..32");
    end

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pend;
    logic               r_ovf;
    logic [3:0]         r_mult_mr;
    logic [3:0]         r_mult_md;

    logic               w_in_fire;
    logic               w_out_fire;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_add_ovf;

    // ------------------------------------------------------------------
    // Handshake and arithmetic helpers
    // ------------------------------------------------------------------
    assign w_in_fire  = in_valid  && (r_state == ACC);
    assign w_out_fire = out_ready && (r_state == DONE);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == CNT_W'(LEN));

    // Size cast of a signed operand sign-extends from bit 7.
    assign w_prod_ext = ACC_W'($signed(mult_product));
    assign w_sum      = r_acc + w_prod_ext;

    // Signed overflow: both addends share a sign the result does not.
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (w_in_fire && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (w_out_fire) begin
                    w_state_nxt = ACC;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, accumulation, counters, overflow
    // ------------------------------------------------------------------
    // The product of the pair captured on the previous edge is summed on
    // the same edge the next pair is captured; r_pend marks that a product
    // is still owed so gaps in in_valid never add a product twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_ovf     <= 1'b0;
            r_mult_mr <= '0;
            r_mult_md <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (r_pend) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_add_ovf;
                    end
                    if (w_in_fire) begin
                        r_mult_mr <= in_mr;
                        r_mult_md <= in_md;
                        r_pend    <= 1'b1;
                        r_cnt     <= w_cnt_inc;
                    end else begin
                        r_pend    <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_acc  <= w_sum;
                    r_ovf  <= r_ovf | w_add_ovf;
                    r_pend <= 1'b0;
                end
                DONE: begin
                    if (w_out_fire) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_pend <= 1'b0;
                end
            endcase
        end
    end

    assign mult_mr = r_mult_mr;
    assign mult_md = r_mult_md;
    assign out_sum = r_acc;
    assign out_ovf = r_ovf;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Directed bench for booth_dot_accumulator. Three instances:
//   0: LEN=4, ACC_W=12   1: LEN=4, ACC_W=8   2: LEN=1, ACC_W=12
// The Booth multiplier is modelled as a plain signed 4x4 product.
module tb_booth_dot_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid     [3];
    logic       in_ready     [3];
    logic [3:0] in_mr        [3];
    logic [3:0] in_md        [3];
    logic [3:0] mult_mr      [3];
    logic [3:0] mult_md      [3];
    logic [7:0] mult_product [3];
    logic       out_valid    [3];
    logic       out_ready    [3];
    logic       out_ovf      [3];
    logic [11:0] sum0;
    logic [7:0]  sum1;
    logic [11:0] sum2;

    int checks;
    int failures;

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    assign mult_product[0] = smul(mult_mr[0], mult_md[0]);
    assign mult_product[1] = smul(mult_mr[1], mult_md[1]);
    assign mult_product[2] = smul(mult_mr[2], mult_md[2]);

    booth_dot_accumulator #(.LEN(4), .ACC_W(12)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mr(in_mr[0]), .in_md(in_md[0]),
        .mult_mr(mult_mr[0]), .mult_md(mult_md[0]),
        .mult_product(mult_product[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_ovf(out_ovf[0])
    );

    booth_dot_accumulator #(.LEN(4), .ACC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mr(in_mr[1]), .in_md(in_md[1]),
        .mult_mr(mult_mr[1]), .mult_md(mult_md[1]),
        .mult_product(mult_product[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_ovf(out_ovf[1])
    );

    booth_dot_accumulator #(.LEN(1), .ACC_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_mr(in_mr[2]), .in_md(in_md[2]),
        .mult_mr(mult_mr[2]), .mult_md(mult_md[2]),
        .mult_product(mult_product[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_ovf(out_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pair at the current negedge; the transfer happens on the
    // following posedge and the task returns on the next negedge.
    task automatic drive_pair(input int d, input logic [3:0] mr, input logic [3:0] md);
        in_valid[d] = 1'b1;
        in_mr[d]    = mr;
        in_md[d]    = md;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Wait (bounded) until out_valid of instance d is high at a negedge.
    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!out_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_mr[d]     = '0;
            in_md[d]     = '0;
            out_ready[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_ovf[d] !== 1'b0 ||
                mult_mr[d] !== 4'h0 || mult_md[d] !== 4'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: in_ready=%b out_valid=%b ovf=%b mr=%h md=%h, want 1 0 0 0 0",
                         d, in_ready[d], out_valid[d], out_ovf[d], mult_mr[d], mult_md[d]);
            end
        end
        checks++;
        if (sum0 !== 12'h000 || sum1 !== 8'h00 || sum2 !== 12'h000) begin
            failures++;
            $display("FAIL reset_sum: got %h %h %h, want 000 00 000", sum0, sum1, sum2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] mr [4];
        logic [3:0] md [4];
        mr = '{4'h3, 4'hE, 4'h8, 4'h1};
        md = '{4'h5, 4'h7, 4'h8, 4'hF};
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready pair%0d: got %b want 1", i, in_ready[0]);
            end
            drive_pair(0, mr[i], md[i]);
        end
        // Cycle after the 4th transfer is DRAIN.
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: in_ready=%b out_valid=%b want 0 0", in_ready[0], out_valid[0]);
        end
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b1 || sum0 !== 12'h040 || out_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: valid=%b sum=%h ovf=%b want 1 040 0", out_valid[0], sum0, out_ovf[0]);
        end
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum0 !== 12'h000) begin
            failures++;
            $display("FAIL b2b_restart: in_ready=%b out_valid=%b sum=%h want 1 0 000",
                     in_ready[0], out_valid[0], sum0);
        end
    endtask

    task automatic test_bubbles;
        logic [3:0] mr [4];
        logic [3:0] md [4];
        int n;
        mr = '{4'h3, 4'hE, 4'h8, 4'h1};
        md = '{4'h5, 4'h7, 4'h8, 4'hF};
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pair(0, mr[i], md[i]);
            if (i < 3) repeat (2) @(negedge clk);
        end
        wait_valid(0, n);
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL bubbles_timeout: out_valid never rose");
        end
        checks++;
        if (sum0 !== 12'h040 || out_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL bubbles_sum: sum=%h ovf=%b want 040 0", sum0, out_ovf[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int n;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) drive_pair(1, 4'h8, 4'h8);
        wait_valid(1, n);
        checks++;
        if (n >= 20 || sum1 !== 8'h00 || out_ovf[1] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_block: wait=%0d sum=%h ovf=%b want <20 00 1", n, sum1, out_ovf[1]);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_pair(1, 4'h1, 4'h1);
        wait_valid(1, n);
        checks++;
        if (n >= 20 || sum1 !== 8'h04 || out_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_next_block: wait=%0d sum=%h ovf=%b want <20 04 0", n, sum1, out_ovf[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int n;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) drive_pair(0, 4'h2, 4'h3);
        in_valid[0] = 1'b1;
        in_mr[0]    = 4'h1;
        in_md[0]    = 4'h1;
        wait_valid(0, n);
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL bp_timeout: out_valid never rose");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || sum0 !== 12'h018 || out_ovf[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: valid=%b sum=%h ovf=%b in_ready=%b want 1 018 0 0",
                         i, out_valid[0], sum0, out_ovf[0], in_ready[0]);
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum0 !== 12'h000) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h want 1 0 000",
                     in_ready[0], out_valid[0], sum0);
        end
        for (int i = 0; i < 4; i++) drive_pair(0, 4'h1, 4'h1);
        wait_valid(0, n);
        checks++;
        if (n >= 20 || sum0 !== 12'h004) begin
            failures++;
            $display("FAIL bp_restart_sum: wait=%0d sum=%h want <20 004", n, sum0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        out_ready[0] = 1'b1;
        drive_pair(0, 4'h5, 4'h5);
        drive_pair(0, 4'h5, 4'h5);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || mult_mr[0] !== 4'h0 || mult_md[0] !== 4'h0) begin
            failures++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b mr=%h md=%h want 1 0 0 0",
                     in_ready[0], out_valid[0], mult_mr[0], mult_md[0]);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_pair(0, 4'h2, 4'h2);
        wait_valid(0, n);
        checks++;
        if (n >= 20 || sum0 !== 12'h010 || out_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_sum: wait=%0d sum=%h ovf=%b want <20 010 0", n, sum0, out_ovf[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_len1;
        out_ready[2] = 1'b0;
        drive_pair(2, 4'h8, 4'h7);
        checks++;
        if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL len1_drain: in_ready=%b out_valid=%b want 0 0", in_ready[2], out_valid[2]);
        end
        @(negedge clk);
        checks++;
        if (out_valid[2] !== 1'b1 || sum2 !== 12'hFC8 || out_ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL len1_result: valid=%b sum=%h ovf=%b want 1 fc8 0", out_valid[2], sum2, out_ovf[2]);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL len1_restart: in_ready=%b out_valid=%b want 1 0", in_ready[2], out_valid[2]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_overflow();
        test_backpressure();
        test_len1();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
